// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with optional parity, 1-2 stop bits and held-data handshake
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_UART_RX,
    input  logic                 i_Rx_Ack,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun,
    output logic                 o_Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF      = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, LOAD} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, live_q, rx_s;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d, ferr_q, ferr_d, stop0_q, stop0_d, arm_q, arm_d;
    logic                 dv_q, dv_d, perr_q, perr_d, fe_q, fe_d, brk_q, brk_d, ovr_q, ovr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 tick, par_bad, brk_now, load, ack;

    assign rx_s    = sync2_q;
    assign tick    = clk_cnt_q == LAST;
    assign par_bad = (PARITY_MODE == 1) ? ~(^shift_q ^ par_q) :
                     (PARITY_MODE == 2) ?  (^shift_q ^ par_q) : 1'b0;
    assign brk_now = (shift_q == '0) && (PARITY_MODE == 0 || !par_q) && !stop0_q;
    assign load    = (state_q == LOAD) && (!dv_q || i_Rx_Ack);
    assign ack     = dv_q && i_Rx_Ack;

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Data    = data_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = fe_q;
    assign o_Break      = brk_q;
    assign o_Overrun    = ovr_q;
    assign o_Busy       = state_q != IDLE;

    // Two-flop synchronizer; live_q masks the reset-forced idle level for one cycle
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            live_q  <= 1'b0;
        end else begin
            sync1_q <= i_UART_RX;
            sync2_q <= sync1_q;
            live_q  <= 1'b1;
        end
    end

    // Frame FSM next state: a start is accepted only after the line has been seen idle (armed)
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ferr_d    = ferr_q;
        stop0_d   = stop0_q;
        arm_d     = (state_q == IDLE) && (arm_q || (rx_s && sync1_q && live_q));
        case (state_q)
            IDLE: begin
                if (arm_q && !rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == HALF) begin
                    state_d   = rx_s ? IDLE : DATA;
                    clk_cnt_d = '0;
                    idx_d     = '0;
                    ferr_d    = 1'b0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    clk_cnt_d = '0;
                    idx_d     = (idx_q == LAST_BIT) ? '0 : idx_q + IW'(1);
                    state_d   = (idx_q != LAST_BIT) ? DATA : (PARITY_MODE != 0) ? PARITY : STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (tick) begin
                    par_d     = rx_s;
                    clk_cnt_d = '0;
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    clk_cnt_d = '0;
                    ferr_d    = ferr_q | !rx_s;
                    stop0_d   = (idx_q == '0) ? rx_s : stop0_q;
                    idx_d     = (idx_q == LAST_STOP) ? '0 : idx_q + IW'(1);
                    state_d   = (idx_q == LAST_STOP) ? LOAD : STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            ferr_q    <= 1'b0;
            stop0_q   <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            ferr_q    <= ferr_d;
            stop0_q   <= stop0_d;
            arm_q     <= arm_d;
        end
    end

    // Held-frame outputs: load wins over ack, a frame arriving while held data is unacked is dropped
    always_comb begin
        dv_d   = load ? 1'b1 : ack ? 1'b0 : dv_q;
        data_d = load ? shift_q : data_q;
        perr_d = load ? par_bad : perr_q;
        fe_d   = load ? ferr_q : fe_q;
        brk_d  = load ? brk_now : brk_q;
        ovr_d  = ack ? 1'b0 : (state_q == LOAD && !load) ? 1'b1 : ovr_q;
    end

    // Held-frame output registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            dv_q   <= 1'b0;
            data_q <= '0;
            perr_q <= 1'b0;
            fe_q   <= 1'b0;
            brk_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            dv_q   <= dv_d;
            data_q <= data_d;
            perr_q <= perr_d;
            fe_q   <= fe_d;
            brk_q  <= brk_d;
            ovr_q  <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized and directed frames on 8N1, 8E1 and slow 8N1 receivers against a frame-level model
module tb_uart_rx_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rx  = 3'b111;
    logic [2:0] ack = 3'b000;
    logic [2:0] dv, perr, fe, brk, ovr, busy;
    logic [7:0] data [3];

    int   cpb [3] = '{16, 16, 868};
    int   pm  [3] = '{0, 2, 0};
    logic       m_dv [3], m_perr [3], m_fe [3], m_brk [3], m_ovr [3];
    logic [7:0] m_data [3];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
        .i_Clk(clk), .i_Rst(rst), .i_UART_RX(rx[0]), .i_Rx_Ack(ack[0]), .o_Rx_DV(dv[0]),
        .o_Rx_Data(data[0]), .o_Parity_Err(perr[0]), .o_Frame_Err(fe[0]), .o_Break(brk[0]),
        .o_Overrun(ovr[0]), .o_Busy(busy[0]));
    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_e1 (
        .i_Clk(clk), .i_Rst(rst), .i_UART_RX(rx[1]), .i_Rx_Ack(ack[1]), .o_Rx_DV(dv[1]),
        .o_Rx_Data(data[1]), .o_Parity_Err(perr[1]), .o_Frame_Err(fe[1]), .o_Break(brk[1]),
        .o_Overrun(ovr[1]), .o_Busy(busy[1]));
    uart_rx_param #(.CLKS_PER_BIT(868), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_slow (
        .i_Clk(clk), .i_Rst(rst), .i_UART_RX(rx[2]), .i_Rx_Ack(ack[2]), .o_Rx_DV(dv[2]),
        .o_Rx_Data(data[2]), .o_Parity_Err(perr[2]), .o_Frame_Err(fe[2]), .o_Break(brk[2]),
        .o_Overrun(ovr[2]), .o_Busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++) begin
            m_dv[s] = 0; m_perr[s] = 0; m_fe[s] = 0; m_brk[s] = 0; m_ovr[s] = 0; m_data[s] = 0;
        end
    endtask

    task automatic check_out(input int s, input string t);
        chk({t, ".dv"},   dv[s],   m_dv[s]);
        chk({t, ".data"}, data[s], m_data[s]);
        chk({t, ".perr"}, perr[s], m_perr[s]);
        chk({t, ".fe"},   fe[s],   m_fe[s]);
        chk({t, ".brk"},  brk[s],  m_brk[s]);
        chk({t, ".ovr"},  ovr[s],  m_ovr[s]);
        chk({t, ".busy"}, busy[s], 0);
    endtask

    task automatic do_ack(input int s, input string t);
        ack[s] = 1'b1;
        tick(1);
        ack[s] = 1'b0;
        if (m_dv[s]) begin
            m_dv[s] = 0;
            m_ovr[s] = 0;
        end
        chk({t, ".ack_dv"}, dv[s], m_dv[s]);
        chk({t, ".ack_ovr"}, ovr[s], m_ovr[s]);
    endtask

    // Drives one whole frame; optionally pulses ack in the cycle the receiver moves the frame out
    task automatic send(input int s, input logic [7:0] d, input logic bad_par, input logic stop_bit,
                        input logic ack_load);
        logic [11:0] bits;
        logic        par;
        int          nb, h;
        par  = ((pm[s] == 1) ? ~^d : ^d) ^ bad_par;
        nb   = (pm[s] != 0) ? 11 : 10;
        bits = (pm[s] != 0) ? {1'b1, stop_bit, par, d, 1'b0} : {2'b11, stop_bit, d, 1'b0};
        h    = (cpb[s] - 1) / 2;
        for (int i = 0; i < nb; i++) begin
            rx[s] = bits[i];
            if (i == nb - 1) begin
                tick(4 + h);
                ack[s] = ack_load;
                tick(1);
                ack[s] = 1'b0;
                tick(cpb[s] - 5 - h);
            end else begin
                tick(cpb[s]);
            end
        end
        rx[s] = 1'b1;
        if (m_dv[s] && ack_load) m_ovr[s] = 0;
        if (!m_dv[s] || ack_load) begin
            m_dv[s]   = 1;
            m_data[s] = d;
            m_perr[s] = (pm[s] == 1) ? (($countones(d) + int'(par)) % 2 != 1) :
                        (pm[s] == 2) ? (($countones(d) + int'(par)) % 2 != 0) : 1'b0;
            m_fe[s]   = !stop_bit;
            m_brk[s]  = (d == 0) && (pm[s] == 0 || par == 0) && !stop_bit;
        end else begin
            m_ovr[s] = 1;
        end
    endtask

    initial begin
        clear_model();
        tick(3);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) check_out(s, "rst");
        tick(4);

        send(0, 8'h3F, 0, 1, 0);
        check_out(0, "n1_3f");
        do_ack(0, "n1_3f");

        send(1, 8'hA5, 1, 1, 0);
        check_out(1, "e1_badpar");
        do_ack(1, "e1_badpar");
        send(1, 8'hA5, 0, 1, 0);
        check_out(1, "e1_goodpar");
        do_ack(1, "e1_goodpar");

        send(0, 8'h11, 0, 1, 0);
        send(0, 8'h22, 0, 1, 0);
        check_out(0, "ovr_hold");
        send(0, 8'h22, 0, 1, 1);
        check_out(0, "ovr_ackload");
        do_ack(0, "ovr_ackload");

        rx[0] = 1'b0;
        tick(12 * 16);
        m_dv[0] = 1; m_data[0] = 0; m_perr[0] = 0; m_fe[0] = 1; m_brk[0] = 1;
        check_out(0, "break");
        do_ack(0, "break");
        tick(48);
        chk("break.no_rearm_dv", dv[0], 0);
        chk("break.no_rearm_busy", busy[0], 0);
        rx[0] = 1'b1;
        tick(32);
        send(0, 8'h5A, 0, 1, 0);
        check_out(0, "after_break");
        do_ack(0, "after_break");

        rx[0] = 1'b0;
        tick(5);
        chk("glitch.busy", busy[0], 1);
        rx[0] = 1'b1;
        tick(20);
        check_out(0, "glitch");

        rx[0] = 1'b0;
        tick(16 * 5 + 8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clear_model();
        for (int s = 0; s < 3; s++) check_out(s, "midrst");
        tick(8);
        rx[0] = 1'b1;
        tick(32);
        check_out(0, "midrst_idle");
        send(0, 8'hC3, 0, 1, 0);
        check_out(0, "midrst_c3");
        do_ack(0, "midrst_c3");

        for (int n = 0; n < 24; n++) begin
            int          s;
            logic [7:0]  d;
            s = n % 2;
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            send(s, d, (s == 1) && ($urandom_range(0, 2) == 0), $urandom_range(0, 3) != 0, 0);
            rx[s] = 1'b1;
            tick(2 * cpb[s]);
            check_out(s, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) != 0) do_ack(s, $sformatf("rnd%0d", n));
        end

        send(2, 8'h3F, 0, 1, 0);
        check_out(2, "slow_3f");
        do_ack(2, "slow_3f");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
